// File: rtl/esm_pkg.sv
// Shared types and default sizing for the ESM issue buffer and its slot array.
package esm_pkg;

    localparam int ESM_INSTR_W = 32;
    localparam int ESM_BS      = 16;
    localparam int ESM_FILL_TH = 4;
    localparam int ESM_IDX_W   = $clog2(ESM_BS);
    localparam int ESM_CNT_W   = ESM_IDX_W + 1;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2
    } esm_state_e;

    typedef struct packed {
        logic [ESM_INSTR_W-1:0] instr;
        logic                   alusrc;
        logic                   regwrite;
        logic                   vld;
    } esm_entry_t;

endpackage

// File: rtl/esm_issue_slot_array.sv
// Entry storage for the issue buffer: one write port, one read port with clear,
// and the per-slot valid vector.
module esm_issue_slot_array
    import esm_pkg::*;
#(
    parameter int W  = ESM_INSTR_W,
    parameter int BS = ESM_BS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [$clog2(BS)-1:0] wr_idx,
    input  logic [W-1:0]          wr_instr,
    input  logic                  wr_alusrc,
    input  logic                  wr_regwrite,
    input  logic [$clog2(BS)-1:0] rd_idx,
    input  logic                  rd_clr,
    output logic [W-1:0]          rd_instr,
    output logic                  rd_alusrc,
    output logic                  rd_regwrite,
    output logic [BS-1:0]         vld
);

    logic [W+1:0]  ent_q [BS];
    logic [W+1:0]  ent_d [BS];
    logic [BS-1:0] vld_q;
    logic [BS-1:0] vld_d;

    // Write and clear never hit the same slot: a write needs vld=0, a clear needs vld=1.
    always_comb begin
        ent_d = ent_q;
        vld_d = vld_q;
        if (rd_clr) begin
            vld_d[rd_idx] = 1'b0;
        end
        if (wr_en) begin
            vld_d[wr_idx] = 1'b1;
            ent_d[wr_idx] = {wr_instr, wr_alusrc, wr_regwrite};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        ent_q <= ent_d;
    end

    assign {rd_instr, rd_alusrc, rd_regwrite} = ent_q[rd_idx];
    assign vld = vld_q;

endmodule

// File: rtl/esm_issue_buffer.sv
// Holding buffer between the ESM core and execute: writes land in buffer_index,
// issues leave from random_index through a single valid/ready output register.
module esm_issue_buffer
    import esm_pkg::*;
#(
    parameter int Instr_word_size = ESM_INSTR_W,
    parameter int bs              = ESM_BS,
    parameter int FILL_TH         = ESM_FILL_TH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [Instr_word_size-1:0] Instr_in,
    input  logic                       ALUSrc,
    input  logic                       RegWrite,
    input  logic [$clog2(bs)-1:0]      buffer_index,
    input  logic                       iss_valid,
    input  logic [$clog2(bs)-1:0]      random_index,
    input  logic                       drain_req,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [Instr_word_size-1:0] Instr_out,
    output logic                       ALUSrc_out,
    output logic                       RegWrite_out,
    output logic [$clog2(bs)-1:0]      out_index,
    output logic [$clog2(bs):0]        count,
    output logic                       wr_collision,
    output logic                       iss_miss
);

    localparam int IDX_W = $clog2(bs);
    localparam int CNT_W = IDX_W + 1;

    esm_state_e                 state_q, state_d;
    logic [CNT_W-1:0]           count_q, count_d;
    logic                       out_valid_q, out_valid_d;
    logic [Instr_word_size-1:0] out_instr_q, out_instr_d;
    logic                       out_alusrc_q, out_alusrc_d;
    logic                       out_regwrite_q, out_regwrite_d;
    logic [IDX_W-1:0]           out_index_q, out_index_d;
    logic                       wr_collision_q, wr_collision_d;
    logic                       iss_miss_q, iss_miss_d;

    logic                       in_ready_c;
    logic                       wr_fire, wr_ok, iss_fire, iss_ok;
    logic [bs-1:0]              vld;
    logic [Instr_word_size-1:0] rd_instr;
    logic                       rd_alusrc, rd_regwrite;

    esm_issue_slot_array #(
        .W  (Instr_word_size),
        .BS (bs)
    ) u_slots (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_ok),
        .wr_idx      (buffer_index),
        .wr_instr    (Instr_in),
        .wr_alusrc   (ALUSrc),
        .wr_regwrite (RegWrite),
        .rd_idx      (random_index),
        .rd_clr      (iss_ok),
        .rd_instr    (rd_instr),
        .rd_alusrc   (rd_alusrc),
        .rd_regwrite (rd_regwrite),
        .vld         (vld)
    );

    always_comb begin
        in_ready_c = (state_q != ST_DRAIN) && (count_q != CNT_W'(bs));
        wr_fire    = in_valid && in_ready_c;
        wr_ok      = wr_fire && !vld[buffer_index];
        iss_fire   = iss_valid && (state_q != ST_FILL) && (!out_valid_q || out_ready);
        iss_ok     = iss_fire && vld[random_index];

        wr_collision_d = wr_fire && vld[buffer_index];
        iss_miss_d     = iss_fire && !vld[random_index];

        count_d = count_q;
        if (wr_ok && !iss_ok) begin
            count_d = count_q + CNT_W'(1);
        end else if (iss_ok && !wr_ok) begin
            count_d = count_q - CNT_W'(1);
        end

        out_valid_d    = out_valid_q;
        out_instr_d    = out_instr_q;
        out_alusrc_d   = out_alusrc_q;
        out_regwrite_d = out_regwrite_q;
        out_index_d    = out_index_q;
        if (iss_ok) begin
            out_valid_d    = 1'b1;
            out_instr_d    = rd_instr;
            out_alusrc_d   = rd_alusrc;
            out_regwrite_d = rd_regwrite;
            out_index_d    = random_index;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // Next state looks at the count/out_valid being registered, so state and count agree.
    always_comb begin
        state_d = state_q;
        if (drain_req) begin
            state_d = ST_DRAIN;
        end else begin
            case (state_q)
                ST_FILL:  if (count_d >= CNT_W'(FILL_TH)) state_d = ST_ISSUE;
                ST_ISSUE: if (count_d == '0) state_d = ST_FILL;
                ST_DRAIN: if (count_d == '0 && !out_valid_d) state_d = ST_FILL;
                default:  state_d = ST_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q        <= '0;
            out_valid_q    <= 1'b0;
            out_instr_q    <= '0;
            out_alusrc_q   <= 1'b0;
            out_regwrite_q <= 1'b0;
            out_index_q    <= '0;
            wr_collision_q <= 1'b0;
            iss_miss_q     <= 1'b0;
        end else begin
            count_q        <= count_d;
            out_valid_q    <= out_valid_d;
            out_instr_q    <= out_instr_d;
            out_alusrc_q   <= out_alusrc_d;
            out_regwrite_q <= out_regwrite_d;
            out_index_q    <= out_index_d;
            wr_collision_q <= wr_collision_d;
            iss_miss_q     <= iss_miss_d;
        end
    end

    assign in_ready     = in_ready_c;
    assign out_valid    = out_valid_q;
    assign Instr_out    = out_instr_q;
    assign ALUSrc_out   = out_alusrc_q;
    assign RegWrite_out = out_regwrite_q;
    assign out_index    = out_index_q;
    assign count        = count_q;
    assign wr_collision = wr_collision_q;
    assign iss_miss     = iss_miss_q;

endmodule

// File: tb/tb_esm_issue_buffer.sv
// Bench for esm_issue_buffer: directed scenarios plus random traffic, all checked
// every cycle against a slot-level behavioural model.
module tb_esm_issue_buffer;

    localparam int W  = 32;
    localparam int BS = 16;
    localparam int TH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  Instr_in = '0;
    logic          ALUSrc = 1'b0;
    logic          RegWrite = 1'b0;
    logic [3:0]    buffer_index = '0;
    logic          iss_valid = 1'b0;
    logic [3:0]    random_index = '0;
    logic          drain_req = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  Instr_out;
    logic          ALUSrc_out;
    logic          RegWrite_out;
    logic [3:0]    out_index;
    logic [4:0]    count;
    logic          wr_collision;
    logic          iss_miss;

    always #5 clk = ~clk;

    esm_issue_buffer #(.Instr_word_size(W), .bs(BS), .FILL_TH(TH)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .Instr_in(Instr_in), .ALUSrc(ALUSrc), .RegWrite(RegWrite),
        .buffer_index(buffer_index), .iss_valid(iss_valid), .random_index(random_index),
        .drain_req(drain_req), .out_valid(out_valid), .out_ready(out_ready),
        .Instr_out(Instr_out), .ALUSrc_out(ALUSrc_out), .RegWrite_out(RegWrite_out),
        .out_index(out_index), .count(count), .wr_collision(wr_collision), .iss_miss(iss_miss)
    );

    // Model: mode 0 = filling, 1 = issuing, 2 = draining
    bit           m_vld [BS];
    logic [W-1:0] m_ins [BS];
    bit           m_a [BS];
    bit           m_r [BS];
    int           m_mode;
    bit           m_ov, m_oa, m_or, m_col, m_miss;
    logic [W-1:0] m_oins;
    int           m_oi;

    int errors = 0;
    int checks = 0;

    function automatic int occupied();
        int n = 0;
        for (int i = 0; i < BS; i++) n += m_vld[i];
        return n;
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < BS; i++) m_vld[i] = 0;
        m_mode = 0; m_ov = 0; m_oins = '0; m_oa = 0; m_or = 0; m_oi = 0;
        m_col = 0; m_miss = 0;
    endtask

    function automatic bit model_in_ready();
        return (m_mode != 2) && (occupied() != BS);
    endfunction

    task automatic model_step();
        bit wr, iss;
        int bi, ri, n;
        bi = int'(buffer_index);
        ri = int'(random_index);
        wr = in_valid && model_in_ready();
        iss = iss_valid && (m_mode != 0) && (!m_ov || out_ready);
        m_col = wr && m_vld[bi];
        m_miss = iss && !m_vld[ri];
        if (iss && m_vld[ri]) begin
            m_ov = 1; m_oins = m_ins[ri]; m_oa = m_a[ri]; m_or = m_r[ri]; m_oi = ri;
            m_vld[ri] = 0;
        end else if (out_ready) begin
            m_ov = 0;
        end
        if (wr && !m_col) begin
            m_vld[bi] = 1; m_ins[bi] = Instr_in; m_a[bi] = ALUSrc; m_r[bi] = RegWrite;
        end
        n = occupied();
        if (drain_req) m_mode = 2;
        else if (m_mode == 0 && n >= TH) m_mode = 1;
        else if (m_mode == 1 && n == 0) m_mode = 0;
        else if (m_mode == 2 && n == 0 && !m_ov) m_mode = 0;
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, m_ov);
        chk("out_index", out_index, m_oi);
        chk("Instr_out", Instr_out, m_oins);
        chk("ALUSrc_out", ALUSrc_out, m_oa);
        chk("RegWrite_out", RegWrite_out, m_or);
        chk("count", count, occupied());
        chk("in_ready", in_ready, model_in_ready());
        chk("wr_collision", wr_collision, m_col);
        chk("iss_miss", iss_miss, m_miss);
    endtask

    task automatic cyc();
        if (rst) model_reset();
        else model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle();
        in_valid = 0; iss_valid = 0; drain_req = 0;
    endtask

    task automatic set_wr(input int idx, input logic [W-1:0] d);
        in_valid = 1; buffer_index = 4'(idx); Instr_in = d;
        ALUSrc = d[0]; RegWrite = d[1];
    endtask

    task automatic set_iss(input int idx);
        iss_valid = 1; random_index = 4'(idx);
    endtask

    task automatic async_reset();
        rst = 1;
        #1;
        model_reset();
        compare_all();
    endtask

    int seq [4] = '{2, 0, 3, 1};
    logic [W-1:0] d;

    initial begin
        // Reset and fill
        model_reset();
        repeat (2) cyc();
        chk("reset_count", count, 0);
        chk("reset_out_valid", out_valid, 0);
        rst = 0;
        #1;
        for (int i = 0; i < 4; i++) begin
            set_wr(i, 32'hA000_0000 + W'(i));
            cyc();
            chk("fill_count", count, i + 1);
            chk("fill_out_valid", out_valid, 0);
        end
        idle();

        // Random issue order 2,0,3,1
        out_ready = 1;
        for (int k = 0; k < 4; k++) begin
            set_iss(seq[k]);
            cyc();
            chk("seq_index", out_index, seq[k]);
            chk("seq_instr", Instr_out, 32'hA000_0000 + seq[k]);
        end
        idle();
        cyc();
        chk("seq_empty", count, 0);
        chk("seq_ov_clear", out_valid, 0);

        // Backpressure
        for (int i = 4; i < 8; i++) begin
            set_wr(i, 32'hB000_0000 + W'(i));
            cyc();
        end
        idle();
        out_ready = 0;
        set_iss(4);
        cyc();
        set_iss(5);
        repeat (3) cyc();
        chk("bp_hold_index", out_index, 4);
        chk("bp_hold_count", count, 3);
        out_ready = 1;
        for (int i = 5; i < 8; i++) begin
            set_iss(i);
            cyc();
            chk("bp_resume", out_index, i);
        end
        idle();
        cyc();

        // Error pulses
        set_wr(5, 32'h5555_0001);
        cyc();
        set_wr(5, 32'h5555_0002);
        cyc();
        chk("collision_pulse", wr_collision, 1);
        idle();
        cyc();
        chk("collision_drop", wr_collision, 0);
        for (int i = 8; i < 11; i++) begin
            set_wr(i, 32'hC000_0000 + W'(i));
            cyc();
        end
        idle();
        set_iss(7);
        cyc();
        chk("miss_pulse", iss_miss, 1);
        chk("miss_count", count, 4);
        set_iss(5);
        cyc();
        chk("collision_kept_old", Instr_out, 32'h5555_0001);
        idle();

        // Full buffer
        for (int i = 0; i < BS; i++) begin
            set_wr(i, $urandom);
            cyc();
        end
        idle();
        cyc();
        chk("full_count", count, 16);
        chk("full_in_ready", in_ready, 0);
        set_iss(3);
        cyc();
        set_wr(3, 32'hD000_0003);
        set_iss(4);
        cyc();
        chk("wr_plus_iss_count", count, 15);
        idle();
        for (int i = 0; i < BS; i++) begin
            set_iss(i);
            cyc();
        end
        idle();
        repeat (2) cyc();
        chk("flush_count", count, 0);

        // Drain with 3 entries
        for (int i = 1; i < 4; i++) begin
            set_wr(i, 32'hE000_0000 + W'(i));
            cyc();
        end
        idle();
        drain_req = 1;
        cyc();
        drain_req = 0;
        chk("drain_in_ready", in_ready, 0);
        for (int i = 1; i < 4; i++) begin
            set_iss(i);
            cyc();
            chk("drain_issue", out_index, i);
        end
        idle();
        for (int k = 0; k < 20 && !in_ready; k++) cyc();
        chk("drain_exit", in_ready, 1);
        chk("drain_exit_count", count, 0);

        // Reset mid-issue
        for (int i = 0; i < 5; i++) begin
            set_wr(i + 9, 32'hF000_0000 + W'(i));
            cyc();
        end
        idle();
        set_iss(10);
        cyc();
        async_reset();
        chk("rst_mid_ov", out_valid, 0);
        chk("rst_mid_count", count, 0);
        chk("rst_mid_instr", Instr_out, 0);
        idle();
        cyc();
        rst = 0;
        #1;

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            idle();
            in_valid = ($urandom_range(0, 99) < 60);
            buffer_index = 4'($urandom_range(0, BS - 1));
            d = $urandom;
            Instr_in = d; ALUSrc = d[0]; RegWrite = d[1];
            iss_valid = ($urandom_range(0, 99) < 55);
            random_index = 4'($urandom_range(0, BS - 1));
            if ($urandom_range(0, 99) < 80) begin
                for (int k = 0; k < BS; k++) begin
                    if (m_vld[(int'(random_index) + k) % BS]) begin
                        random_index = 4'((int'(random_index) + k) % BS);
                        break;
                    end
                end
            end
            out_ready = ($urandom_range(0, 99) < 70);
            drain_req = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 999) == 0) begin
                async_reset();
                cyc();
                rst = 0;
                #1;
            end else begin
                cyc();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
